// File: rtl/pe_xbar_ctx_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_xbar_ctx_seq
// Purpose  : Context sequencer for the 5-input/4-output PE crossbar. Holds a
//            table of crossbar switch words written through a config port.
//            On start it steps through contexts 0..ctx_num-1, one per
//            non-stalled cycle, repeating iter_num times. The crossbar switch
//            word is driven from a register.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            cfg_we/addr/data    context table write port
//            start               launch pulse (ctx_num, iter_num sampled)
//            ctx_num, iter_num   contexts per iteration, iteration count
//            stall               freeze sequencing
//            switch              registered crossbar switch word
//            ctx_idx             index of the context currently on switch
//            busy, done          RUN indicator, one-cycle completion pulse
//            cfg_err             one-cycle pulse on a rejected write
// Options  : XBAR_SEL_CHECK_EN   reject writes whose 3-bit fields hold 5..7
// Revision : 1.0  initial release
// ============================================================================
module pe_xbar_ctx_seq #(
  parameter int SW_W      = 12,
  parameter int CTX_DEPTH = 16,
  parameter int AW        = 4,
  parameter int ITER_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [SW_W-1:0]   cfg_data,
  input  logic              start,
  input  logic [AW:0]       ctx_num,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              stall,
  output logic [SW_W-1:0]   switch,
  output logic [AW-1:0]     ctx_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [AW:0] CTX_MAX = (AW+1)'(CTX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SW_W-1:0]   ctx_tbl [CTX_DEPTH];
  logic [AW-1:0]     last_idx_q;   // ctx_num-1 after clamping
  logic [ITER_W-1:0] iter_last_q;  // iter_num-1
  logic [ITER_W-1:0] iter_cnt_q;

  logic              sel_bad;
  logic              tbl_we;
  logic              start_ok;
  logic [AW:0]       ctx_clamped;
  logic              ctx_at_end;
  logic              iter_at_end;
  logic [AW-1:0]     rd_idx;

`ifdef XBAR_SEL_CHECK_EN
  // Field encodings 5..7 have no crossbar source behind them.
  function automatic logic has_bad_sel(input logic [SW_W-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int f = 0; f < SW_W/3; f++) begin
      if (d[3*f+2] && (d[3*f+1] || d[3*f])) bad = 1'b1;
    end
    return bad;
  endfunction
  assign sel_bad = has_bad_sel(cfg_data);
`else
  assign sel_bad = 1'b0;
`endif

  assign tbl_we      = cfg_we && (state_q != S_RUN) && !sel_bad;
  assign start_ok    = start && (ctx_num != '0) && (iter_num != '0);
  assign ctx_clamped = (ctx_num > CTX_MAX) ? CTX_MAX : ctx_num;
  assign ctx_at_end  = (ctx_idx == last_idx_q);
  assign iter_at_end = (iter_cnt_q == iter_last_q);
  // Only the advance-within-iteration case reads anything but entry 0.
  assign rd_idx      = (state_q == S_RUN && !ctx_at_end) ? ctx_idx + AW'(1) : '0;

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_we) ctx_tbl[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = start_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (!stall && ctx_at_end && iter_at_end) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch      <= '0;
      ctx_idx     <= '0;
      last_idx_q  <= '0;
      iter_last_q <= '0;
      iter_cnt_q  <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ((state_q == S_RUN) || sel_bad);
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            last_idx_q  <= AW'(ctx_clamped - (AW+1)'(1));
            iter_last_q <= iter_num - ITER_W'(1);
            iter_cnt_q  <= '0;
            ctx_idx     <= '0;
            switch      <= ctx_tbl[rd_idx];
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (!ctx_at_end) begin
              ctx_idx <= rd_idx;
              switch  <= ctx_tbl[rd_idx];
            end else if (!iter_at_end) begin
              ctx_idx    <= '0;
              switch     <= ctx_tbl[rd_idx];
              iter_cnt_q <= iter_cnt_q + ITER_W'(1);
            end
          end
        end
        default: ;  // DONE: switch and index hold
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_xbar_ctx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_xbar_ctx_seq
// Purpose  : Directed self-checking bench for pe_xbar_ctx_seq.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_xbar_ctx_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        start;
  logic [4:0]  ctx_num;
  logic [15:0] iter_num;
  logic        stall;
  logic [11:0] switch;
  logic [3:0]  ctx_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int total;
  int bad;

  pe_xbar_ctx_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .start    (start),
    .ctx_num  (ctx_num),
    .iter_num (iter_num),
    .stall    (stall),
    .switch   (switch),
    .ctx_idx  (ctx_idx),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [11:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Leaves the bench just after the edge that sampled start (cycle 1).
  task automatic start_seq(input logic [4:0] n, input logic [15:0] it);
    ctx_num  = n;
    iter_num = it;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  function automatic logic [11:0] clamp_word(input int c);
    return {3'((c) % 5), 3'((c + 1) % 5), 3'((c + 2) % 5), 3'((c + 3) % 5)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (switch !== 12'h000) begin bad++; $display("FAIL reset_switch got %h want 000", switch); end
    total++; if ({busy, done, cfg_err, ctx_idx} !== 7'b0) begin bad++;
      $display("FAIL reset_flags got busy=%b done=%b err=%b idx=%0d want 0", busy, done, cfg_err, ctx_idx); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    write_entry(4'd0, 12'h123);
    start_seq(5'd1, 16'd100);
    tick();
    total++; if (switch !== 12'h123 || busy !== 1'b1) begin bad++;
      $display("FAIL midrun_pre got switch=%h busy=%b want 123/1", switch, busy); end
    #2; rst_n = 1'b0; #1;
    total++; if (switch !== 12'h000 || busy !== 1'b0 || ctx_idx !== 4'd0 || done !== 1'b0) begin bad++;
      $display("FAIL midrun_reset got switch=%h busy=%b idx=%0d done=%b want 000/0/0/0", switch, busy, ctx_idx, done); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL post_reset_idle got done=%b busy=%b want 0/0", done, busy); end
    end
  endtask

  task automatic test_basic();
    logic [11:0] exp_sw [3];
    exp_sw[0] = 12'h000; exp_sw[1] = 12'h249; exp_sw[2] = 12'h924;
    write_entry(4'd0, 12'h000);
    write_entry(4'd1, 12'h249);
    write_entry(4'd2, 12'h924);
    start_seq(5'd3, 16'd2);
    for (int c = 1; c <= 6; c++) begin
      total++; if (switch !== exp_sw[(c-1)%3] || ctx_idx !== 4'((c-1)%3) || busy !== 1'b1 || done !== 1'b0) begin bad++;
        $display("FAIL basic_c%0d got switch=%h idx=%0d busy=%b done=%b want %h/%0d/1/0",
                 c, switch, ctx_idx, busy, done, exp_sw[(c-1)%3], (c-1)%3); end
      tick();
    end
    total++; if (done !== 1'b1 || busy !== 1'b0 || switch !== 12'h924) begin bad++;
      $display("FAIL basic_done got done=%b busy=%b switch=%h want 1/0/924", done, busy, switch); end
    tick();
    total++; if (done !== 1'b0 || switch !== 12'h924) begin bad++;
      $display("FAIL basic_after got done=%b switch=%h want 0/924", done, switch); end
  endtask

  task automatic test_stall();
    logic [11:0] exp_sw [8];
    logic [3:0]  exp_ix [8];
    exp_sw = '{12'h000, 12'h249, 12'h249, 12'h249, 12'h924, 12'h000, 12'h249, 12'h924};
    exp_ix = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    start_seq(5'd3, 16'd2);
    for (int c = 1; c <= 8; c++) begin
      total++; if (switch !== exp_sw[c-1] || ctx_idx !== exp_ix[c-1] || busy !== 1'b1) begin bad++;
        $display("FAIL stall_c%0d got switch=%h idx=%0d busy=%b want %h/%0d/1",
                 c, switch, ctx_idx, busy, exp_sw[c-1], exp_ix[c-1]); end
      stall = (c == 2 || c == 3);
      tick();
    end
    stall = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL stall_done got done=%b busy=%b want 1/0", done, busy); end
    tick();
  endtask

  task automatic test_degenerate();
    start_seq(5'd0, 16'd5);
    total++; if (done !== 1'b1 || busy !== 1'b0 || switch !== 12'h924) begin bad++;
      $display("FAIL degen_ctx0 got done=%b busy=%b switch=%h want 1/0/924", done, busy, switch); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL degen_after got done=%b busy=%b want 0/0", done, busy); end
    start_seq(5'd3, 16'd0);
    total++; if (done !== 1'b1 || busy !== 1'b0 || switch !== 12'h924) begin bad++;
      $display("FAIL degen_iter0 got done=%b busy=%b switch=%h want 1/0/924", done, busy, switch); end
    tick();
  endtask

  task automatic test_run_write();
    start_seq(5'd3, 16'd2);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 12'hFFF;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL runwr_err got %b want 1", cfg_err); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL runwr_err_clear got %b want 0", cfg_err); end
    repeat (4) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL runwr_done got %b want 1", done); end
    tick();
    start_seq(5'd3, 16'd1);
    tick();
    total++; if (switch !== 12'h249) begin bad++; $display("FAIL runwr_rerun got %h want 249", switch); end
    tick();
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL runwr_rerun_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_sel_check();
    write_entry(4'd1, 12'h005);
`ifdef XBAR_SEL_CHECK_EN
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL sel_reject_err got %b want 1", cfg_err); end
`else
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL sel_accept_err got %b want 0", cfg_err); end
`endif
    start_seq(5'd3, 16'd1);
    tick();
`ifdef XBAR_SEL_CHECK_EN
    total++; if (switch !== 12'h249) begin bad++; $display("FAIL sel_reject_keep got %h want 249", switch); end
`else
    total++; if (switch !== 12'h005) begin bad++; $display("FAIL sel_accept_store got %h want 005", switch); end
`endif
    repeat (3) tick();
    write_entry(4'd1, 12'h924);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL sel_good_err got %b want 0", cfg_err); end
    start_seq(5'd3, 16'd1);
    tick();
    total++; if (switch !== 12'h924) begin bad++; $display("FAIL sel_good_store got %h want 924", switch); end
    repeat (3) tick();
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++) write_entry(4'(i), clamp_word(i));
    start_seq(5'd31, 16'd1);
    for (int c = 0; c < 16; c++) begin
      total++; if (ctx_idx !== 4'(c) || switch !== clamp_word(c) || busy !== 1'b1) begin bad++;
        $display("FAIL clamp_c%0d got idx=%0d switch=%h busy=%b want %0d/%h/1",
                 c, ctx_idx, switch, busy, c, clamp_word(c)); end
      tick();
    end
    total++; if (done !== 1'b1 || switch !== clamp_word(15)) begin bad++;
      $display("FAIL clamp_done got done=%b switch=%h want 1/%h", done, switch, clamp_word(15)); end
    tick();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    start    = 1'b0;
    ctx_num  = '0;
    iter_num = '0;
    stall    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_degenerate();
    test_run_write();
    test_sel_check();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_xbar_ctx_seq.md
Name: pe_xbar_ctx_seq

Overview:
- Context sequencer for the 5-input/4-output PE crossbar.
- Holds a small table of crossbar switch words, loaded through a config port.
- On start, steps through contexts 0..ctx_num-1, one per non-stalled cycle, repeating iter_num times.
- Drives the crossbar's 12-bit switch input from a register. Sits between the PE config/loader logic and the crossbar.

Parameters:
- SW_W, 12 (`PE_5x4): switch word width, 4 fields x 3 bits.
- CTX_DEPTH, 16: context table entries; must be a power of 2.
- AW, 4: address width, log2(CTX_DEPTH).
- ITER_W, 16: iteration counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  context table write strobe.
- cfg_addr  in  AW  write address.
- cfg_data  in  SW_W  switch word; fields are R0[11:9], R1[8:6], R2[5:3], R3[2:0].
- start  in  1  launch-sequence pulse.
- ctx_num  in  AW+1  contexts per iteration, 0..CTX_DEPTH; sampled at start.
- iter_num  in  ITER_W  iteration count; sampled at start.
- stall  in  1  freeze sequencing.
- switch  out  SW_W  registered crossbar switch word.
- ctx_idx  out  AW  index of the context currently on switch.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; switch=0 (all outputs select din_N); ctx_idx=0; busy=0; done=0; cfg_err=0; iteration counter=0.
  - Table contents are not reset.
  - Reset mid-RUN aborts immediately; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes table[cfg_addr]=cfg_data at the clock edge.
  - start with ctx_num!=0 and iter_num!=0: latch both, go to RUN. Next cycle switch=table[0], ctx_idx=0, busy=1. Latency start->first switch word is 1 cycle.
  - start with ctx_num==0 or iter_num==0: go to DONE; switch unchanged.
  - ctx_num>CTX_DEPTH is clamped to CTX_DEPTH.
- RUN, stall=0, each cycle:
  - If ctx_idx<ctx_num-1: ctx_idx+1, switch=table[ctx_idx+1].
  - Else, if iteration counter<iter_num-1: ctx_idx=0, switch=table[0], iteration counter+1 (wrap-around).
  - Else: go to DONE.
- RUN, stall=1: switch, ctx_idx and counters all hold. A stall asserted on the last context delays DONE.
- RUN, cfg_we: write ignored; cfg_err pulses the following cycle.
- RUN, start: ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - switch holds the last context word through DONE and IDLE until the next start.
  - start in DONE is ignored.
  - cfg_we in DONE is accepted, as in IDLE.
- Table read is combinational from the register array. switch is a registered copy of that read.
- Iteration counter is ITER_W bits and has no overflow, because it is bounded by iter_num-1.
- Total RUN cycles without stall = ctx_num*iter_num.

Optional Feature:
- Macro: XBAR_SEL_CHECK_EN.
- Defined:
  - A write is rejected if any 3-bit field of cfg_data is 5, 6 or 7 (encodings the crossbar does not define).
  - On rejection the table entry is unchanged and cfg_err pulses one cycle after.
- Undefined: every write accepted in IDLE/DONE is stored unchanged. cfg_err reports only writes made during RUN.

Test Plan:
- Reset: rst_n low mid-RUN with switch=12'h123 -> switch=0, busy=0, ctx_idx=0 in the same cycle; no done pulse.
- Basic sequence:
  - Stimulus: write table[0..2]=12'h000, 12'h249, 12'h924; start with ctx_num=3, iter_num=2.
  - Cycles 1-6 after start: switch = 000, 249, 924, 000, 249, 924.
  - Cycle 7: done=1, busy=0. switch holds 924.
- Stall: same setup with stall high for 2 cycles while switch=12'h249 -> switch and ctx_idx=1 hold 2 extra cycles; done arrives at cycle 9.
- Degenerate start: start with ctx_num=0, iter_num=5 -> done pulse 1 cycle later; switch unchanged; busy never set.
- Write during RUN: cfg_we to addr 1 with 12'hFFF during RUN -> cfg_err pulses; a rerun still shows 12'h249 at index 1.
- With XBAR_SEL_CHECK_EN:
  - Write 12'h005 (R3 field=5) in IDLE -> rejected, cfg_err=1, entry keeps its old value.
  - Write 12'h924 -> accepted.
